// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer for the pipelined RISC-V core.
// Owns the PC, addresses the combinational instruction ROM and loads the
// IF/ID pipeline register. It handles hazard stalls and EX redirects, and it
// stops fetching speculatively when it sees the all-zero end-of-program word.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;

  assign fetch_pc = pc;
  assign halted   = (state == HALT);

  // Fetch sequencer. Priority is reset, then redirect, then HALT or stall, then a
  // normal fetch. A redirect only clears IF/ID valid and leaves the old pc and
  // instruction fields in place. The halt word never enters IF/ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'd0;
      if_id_instr <= 32'd0;
      fetch_count <= 32'd0;
    end else if (redirect_valid) begin
      state       <= RUN;
      pc          <= {redirect_pc[31:2], 2'b00};
      if_id_valid <= 1'b0;
    end else if (state == HALT) begin
      if_id_valid <= 1'b0;
    end else if (stall) begin
      // Hold pc, IF/ID and the counter while the hazard unit stalls us.
    end else if (fetch_instr == 32'h0000_0000) begin
      state       <= HALT;
      if_id_valid <= 1'b0;
    end else begin
      if_id_valid <= 1'b1;
      if_id_pc    <= pc;
      if_id_instr <= fetch_instr;
      pc          <= pc + 32'd4;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. It runs a directed vector
// table against a small program ROM, then random stall, redirect and reset
// traffic against a random ROM that is checked by a rule-level model. Last, a
// second instance starts near the top of the address space to exercise PC wrap.

module tb_fetch_unit;

  localparam logic [31:0] I0 = 32'h00a00513;
  localparam logic [31:0] I1 = 32'h00108093;
  localparam logic [31:0] I2 = 32'hfea0cee3;

  logic        clk;
  logic        rst0, stall0, redir0;
  logic [31:0] rpc0;
  logic [31:0] fetch_pc0, fetch_instr0, if_id_pc0, if_id_instr0, fetch_count0;
  logic        if_id_valid0, halted0;

  logic        rst1, stall1, redir1;
  logic [31:0] rpc1;
  logic [31:0] fetch_pc1, fetch_instr1, if_id_pc1, if_id_instr1, fetch_count1;
  logic        if_id_valid1, halted1;

  int check_count;
  int error_count;

  logic        rom_mode;
  logic [31:0] rom_table [64];

  // Reference state, updated once per clock edge from the written rules.
  logic [31:0] m_pc, m_if_pc, m_if_instr, m_count;
  logic        m_valid, m_halted;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        halted;
    logic [31:0] count;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(.RESET_PC(32'd0)) dut0 (
    .clk(clk), .rst(rst0), .stall(stall0), .redirect_valid(redir0),
    .redirect_pc(rpc0), .fetch_pc(fetch_pc0), .fetch_instr(fetch_instr0),
    .if_id_valid(if_id_valid0), .if_id_pc(if_id_pc0),
    .if_id_instr(if_id_instr0), .halted(halted0), .fetch_count(fetch_count0)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFF8)) dut1 (
    .clk(clk), .rst(rst1), .stall(stall1), .redirect_valid(redir1),
    .redirect_pc(rpc1), .fetch_pc(fetch_pc1), .fetch_instr(fetch_instr1),
    .if_id_valid(if_id_valid1), .if_id_pc(if_id_pc1),
    .if_id_instr(if_id_instr1), .halted(halted1), .fetch_count(fetch_count1)
  );

  // 10-unit core clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational ROM for the first instance: small program or random table.
  always_comb begin
    fetch_instr0 = 32'h0;
    if (rom_mode) begin
      fetch_instr0 = rom_table[fetch_pc0[7:2]];
    end else begin
      case (fetch_pc0)
        32'd0:   fetch_instr0 = I0;
        32'd4:   fetch_instr0 = I1;
        32'd8:   fetch_instr0 = I2;
        default: fetch_instr0 = 32'h0;
      endcase
    end
  end

  // The second instance sees a NOP at every address.
  assign fetch_instr1 = 32'h00000013;

  function automatic logic [31:0] model_rom(input logic mode, input logic [31:0] addr);
    if (mode) return rom_table[addr[7:2]];
    if (addr == 32'd0) return I0;
    if (addr == 32'd4) return I1;
    if (addr == 32'd8) return I2;
    return 32'h0;
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic rv,
                              input logic [31:0] rp, input logic [31:0] pc,
                              input logic v, input logic [31:0] ipc,
                              input logic [31:0] iin, input logic h,
                              input logic [31:0] cnt);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = rv; t.rpc = rp; t.pc = pc; t.valid = v;
    t.if_pc = ipc; t.if_instr = iin; t.halted = h; t.count = cnt;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance the reference by one edge: a fetch either redirects, bubbles,
  // holds, halts on the zero word, or accepts one instruction and moves on.
  task automatic model_edge(input logic r, input logic s, input logic rv,
                            input logic [31:0] rp, input logic [31:0] instr);
    if (r) begin
      m_pc = 32'd0; m_halted = 1'b0; m_valid = 1'b0;
      m_if_pc = 32'd0; m_if_instr = 32'd0; m_count = 32'd0;
    end else if (rv) begin
      m_pc = rp & ~32'd3; m_halted = 1'b0; m_valid = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (!s) begin
      if (instr == 32'd0) begin
        m_halted = 1'b1; m_valid = 1'b0;
      end else begin
        m_valid = 1'b1; m_if_pc = m_pc; m_if_instr = instr;
        m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic rv,
                               input logic [31:0] rp);
    logic [31:0] instr;
    rst0 = r; stall0 = s; redir0 = rv; rpc0 = rp;
    instr = model_rom(rom_mode, m_pc);
    model_edge(r, s, rv, rp, instr);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag);
    checkOutput({tag, " pc"},       fetch_pc0,            m_pc);
    checkOutput({tag, " valid"},    {31'd0, if_id_valid0}, {31'd0, m_valid});
    checkOutput({tag, " halted"},   {31'd0, halted0},     {31'd0, m_halted});
    checkOutput({tag, " count"},    fetch_count0,         m_count);
    if (m_valid) begin
      checkOutput({tag, " if_pc"},    if_id_pc0,    m_if_pc);
      checkOutput({tag, " if_instr"}, if_id_instr0, m_if_instr);
    end
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    rom_mode = 1'b0;
    rst0 = 1'b1; stall0 = 1'b0; redir0 = 1'b0; rpc0 = 32'd0;
    rst1 = 1'b1; stall1 = 1'b0; redir1 = 1'b0; rpc1 = 32'd0;
    m_pc = 32'd0; m_if_pc = 32'd0; m_if_instr = 32'd0; m_count = 32'd0;
    m_valid = 1'b0; m_halted = 1'b0;
    for (int i = 0; i < 64; i++) rom_table[i] = 32'h0;

    // Directed table: run to halt, redirect out, stall, redirect+stall,
    // reset in HALT, reset over redirect+stall, redirect to the current pc.
    vecs.push_back(mk(1,0,0,0,          32'h0, 0, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0,0,0,0,          32'h4, 1, 32'h0, I0,    0, 1));
    vecs.push_back(mk(0,0,0,0,          32'h8, 1, 32'h4, I1,    0, 2));
    vecs.push_back(mk(0,0,0,0,          32'hC, 1, 32'h8, I2,    0, 3));
    vecs.push_back(mk(0,0,0,0,          32'hC, 0, 32'h8, I2,    1, 3));
    vecs.push_back(mk(0,1,0,0,          32'hC, 0, 32'h8, I2,    1, 3));
    vecs.push_back(mk(0,0,1,32'h4,      32'h4, 0, 32'h8, I2,    0, 3));
    vecs.push_back(mk(0,0,0,0,          32'h8, 1, 32'h4, I1,    0, 4));
    vecs.push_back(mk(0,1,0,0,          32'h8, 1, 32'h4, I1,    0, 4));
    vecs.push_back(mk(0,1,0,0,          32'h8, 1, 32'h4, I1,    0, 4));
    vecs.push_back(mk(0,1,0,0,          32'h8, 1, 32'h4, I1,    0, 4));
    vecs.push_back(mk(0,0,0,0,          32'hC, 1, 32'h8, I2,    0, 5));
    vecs.push_back(mk(0,1,1,32'h7,      32'h4, 0, 32'h8, I2,    0, 5));
    vecs.push_back(mk(0,0,0,0,          32'h8, 1, 32'h4, I1,    0, 6));
    vecs.push_back(mk(0,0,0,0,          32'hC, 1, 32'h8, I2,    0, 7));
    vecs.push_back(mk(0,0,0,0,          32'hC, 0, 32'h8, I2,    1, 7));
    vecs.push_back(mk(1,0,0,0,          32'h0, 0, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0,0,0,0,          32'h4, 1, 32'h0, I0,    0, 1));
    vecs.push_back(mk(1,1,1,32'h8,      32'h0, 0, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0,0,0,0,          32'h4, 1, 32'h0, I0,    0, 1));
    vecs.push_back(mk(0,0,1,32'h4,      32'h4, 0, 32'h0, I0,    0, 1));
    vecs.push_back(mk(0,0,0,0,          32'h8, 1, 32'h4, I1,    0, 2));

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
      checkOutput({tag, " pc"},       fetch_pc0,             vecs[i].pc);
      checkOutput({tag, " valid"},    {31'd0, if_id_valid0}, {31'd0, vecs[i].valid});
      checkOutput({tag, " if_pc"},    if_id_pc0,             vecs[i].if_pc);
      checkOutput({tag, " if_instr"}, if_id_instr0,          vecs[i].if_instr);
      checkOutput({tag, " halted"},   {31'd0, halted0},      {31'd0, vecs[i].halted});
      checkOutput({tag, " count"},    fetch_count0,          vecs[i].count);
    end

    // Random phase: random ROM with roughly one zero word in six.
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 5) == 0) rom_table[i] = 32'h0;
      else rom_table[i] = $urandom | 32'h1;
    end
    rom_mode = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    compare_model("rand_reset");
    for (int i = 0; i < 600; i++) begin
      logic        r, s, rv;
      logic [31:0] rp;
      r  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0);
      rp = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
      applyStimulus(r, s, rv, rp);
      compare_model($sformatf("rand%0d", i));
    end

    // PC wrap on the second instance: NOP everywhere, reset just below 2^32.
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("wrap reset pc", fetch_pc1, 32'hFFFFFFF8);
    checkOutput("wrap reset valid", {31'd0, if_id_valid1}, 32'd0);
    rst1 = 1'b0;
    begin
      logic [31:0] exp_pc;
      exp_pc = 32'hFFFFFFF8;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        checkOutput($sformatf("wrap%0d if_pc", k), if_id_pc1, exp_pc);
        exp_pc = exp_pc + 32'd4;
        checkOutput($sformatf("wrap%0d pc", k), fetch_pc1, exp_pc);
        checkOutput($sformatf("wrap%0d valid", k), {31'd0, if_id_valid1}, 32'd1);
        checkOutput($sformatf("wrap%0d count", k), fetch_count1, 32'(k + 1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer for the pipelined RISC-V core. Owns the program counter, drives the address into the combinational instruction ROM, and loads the IF/ID pipeline register. It applies hazard stalls and branch/jump redirects from later stages. It also stops fetching when the ROM returns the all-zero end-of-program word; this halt is speculative, so a later redirect resumes fetch.

## Interface

Parameters:
- RESET_PC, 32'd0: PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  from hazard unit; hold PC and IF/ID contents.
- redirect_valid  in  1  taken branch/jump from EX; flush and load new PC.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 00 when loaded.
- fetch_pc  out  32  address to instruction ROM; equals internal PC register.
- fetch_instr  in  32  ROM data for fetch_pc, valid in the same cycle.
- if_id_valid  out  1  IF/ID register holds a real instruction.
- if_id_pc  out  32  PC of the instruction in IF/ID.
- if_id_instr  out  32  instruction word in IF/ID.
- halted  out  1  fetch is in HALT state.
- fetch_count  out  32  number of instructions loaded into IF/ID with valid=1.

## Operation

- States: RUN and HALT. halted = (state == HALT).
- Reset (rst=1 at an edge) sets:
  - state=RUN, pc=RESET_PC.
  - if_id_valid=0, if_id_pc=0, if_id_instr=0.
  - fetch_count=0.
  - Reset overrides every other input.
- Priority at each edge: rst > redirect_valid > stall > normal fetch.
- redirect_valid=1, in either state:
  - pc <= {redirect_pc[31:2], 2'b00}; state <= RUN.
  - if_id_valid <= 0. if_id_pc and if_id_instr hold their values.
  - stall is ignored that cycle.
  - fetch_count is unchanged.
- RUN, no redirect, stall=1: pc, if_id_* and fetch_count all hold.
- RUN, no redirect, stall=0, fetch_instr == 32'h00000000:
  - state <= HALT; pc holds.
  - if_id_valid <= 0; fetch_count is unchanged.
- RUN, no redirect, stall=0, fetch_instr != 0:
  - if_id_valid <= 1, if_id_pc <= pc, if_id_instr <= fetch_instr.
  - pc <= pc + 4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
  - fetch_count <= fetch_count + 1, wrapping at 2^32.
- HALT, no redirect:
  - pc holds; if_id_valid <= 0 regardless of stall.
  - fetch_count holds.
  - Only a redirect or reset leaves HALT.
- The halt word is never presented as valid in IF/ID.
- Redirect to the current pc is legal: it flushes IF/ID and refetches.

## Timing

- fetch_pc is a register output. The ROM is combinational, so fetch_instr is sampled on the next edge.
- Fetch latency is 1 cycle: the instruction at fetch_pc appears in IF/ID after the next rising edge.
- Throughput is 1 instruction per cycle when stall=0.
- Redirect asserted in cycle N:
  - Edge ending N: pc=target, if_id_valid=0.
  - Edge ending N+1: target instruction is in IF/ID with if_id_valid=1, provided there is no stall or halt word.
  - Redirect penalty is one bubble from this unit; the upstream flush of ID is the owner stage's job.
- Redirect and stall in the same cycle: redirect wins; the bubble is inserted.
- halted rises at the edge that samples the zero word and falls at the edge that applies a redirect.
- rst asserted mid-stall or in HALT: state returns to RUN and pc=RESET_PC at that edge. The first fetch result is one edge after rst deasserts.

## Test plan

- Reset then run, ROM = {0:00a00513, 4:00108093, 8:fea0cee3, else 0}, no stall/redirect:
  - IF/ID sequence is (0,00a00513), (4,00108093), (8,fea0cee3).
  - At pc=12, halted=1 and if_id_valid=0; pc stays 12.
  - fetch_count=3.
- Same ROM, redirect_valid=1 with redirect_pc=4 one cycle after halted rises:
  - halted=0 next edge, pc=4, if_id_valid=0.
  - Following edge: IF/ID=(4,00108093); fetch_count increments.
- Stall held for 3 cycles while IF/ID=(4,00108093):
  - pc=8 and IF/ID are unchanged throughout; fetch_count is constant.
  - On release, IF/ID=(8,fea0cee3) after one edge.
- Redirect and stall both asserted, redirect_pc=32'h00000007:
  - pc=4 (low bits masked), if_id_valid=0; the stall is ignored.
- RESET_PC=32'hFFFFFFF8, ROM returns 32'h00000013 everywhere:
  - pc sequence is FFFFFFF8, FFFFFFFC, 00000000, 00000004.
  - if_id_valid=1 every cycle.
- rst asserted for 1 cycle while in HALT with fetch_count=5:
  - Next edge: halted=0, pc=RESET_PC, if_id_valid=0, fetch_count=0.
